// File: rtl/preadd_port_bd_pkg.sv
// Shared definitions for the B/D pre-adder input port.
//  - B_INPUT selector strings (stage-0 source: B or BCIN)
//  - opmode_t: the two opcode bits the port consumes (OPMODE4 pre-add select, OPMODE6 subtract)
//  - sat_limit(): signed saturation bound for a given width, returned in the low bits of 48
package preadd_port_bd_pkg;

  localparam string BInputDirect  = "DIRECT";
  localparam string BInputCascade = "CASCADE";

  typedef struct packed {
    logic sub;     // OPMODE6: 1 -> D - B, 0 -> D + B
    logic preadd;  // OPMODE4: 1 -> B1 takes the pre-adder result
  } opmode_t;

  // Largest positive (negative=0) or most negative (negative=1) two's-complement value of
  // `width` bits. Only bits [width-1:0] of the result are meaningful.
  function automatic logic [47:0] sat_limit(int unsigned width, logic negative);
    logic [47:0] lim;
    lim            = '0;
    lim[width-1]   = 1'b1;
    if (!negative) lim = lim - 48'd1;
    return lim;
  endfunction

endpackage

// File: rtl/preadd_port_bd_pipe_reg.sv
// DEPTH-stage register chain with clock enable, synchronous clear and asynchronous reset.
// DEPTH = 0 degenerates to a wire.
//  clk_i  : rising-edge clock
//  rst_ni : asynchronous active-low reset, clears every stage
//  ce_i   : stage enable; 0 holds all stages
//  clr_i  : synchronous clear of all stages, takes effect only when ce_i = 1
//  d_i    : chain input
//  q_o    : chain output (last stage)
module preadd_port_bd_pipe_reg #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ce_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, ce_i, clr_i};
    assign q_o         = d_i;
  end else begin : g_regs
    logic [DEPTH-1:0][W-1:0] stage_q, stage_d;

    always_comb begin
      stage_d = stage_q;
      if (clr_i) begin
        stage_d = '0;
      end else begin
        stage_d[0] = d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else if (ce_i) begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/preadd_port_bd.sv
// Parametrised B/D input port with wrap/saturate pre-adder feeding the multiplier B operand.
//  clk_i        : rising-edge clock
//  rst_ni       : asynchronous active-low reset of every register
//  b_i, bcin_i  : direct / cascade B operand (B_INPUT picks one at elaboration)
//  d_i          : pre-adder D operand
//  opmode4_i    : 1 -> B1 = pre-add result, 0 -> B1 = B path
//  opmode6_i    : 1 -> D - B, 0 -> D + B
//  ce_i         : pipeline enable, freezes data and valid together
//  rstb_i       : sync clear of B input stages, B1 and OVF (gated by ce_i)
//  rstd_i       : sync clear of D input stages (gated by ce_i)
//  in_vld_i     : input sample valid
//  out_b1_o     : result to multiplier; bcout_o is an identical cascade copy
//  ovf_o        : carry/borrow (wrap) or saturation flag, aligned with out_b1_o
//  out_vld_o    : in_vld_i delayed by IN_DEPTH + B1REG enabled cycles
module preadd_port_bd
  import preadd_port_bd_pkg::*;
#(
  parameter int unsigned WIDTH     = 18,
  parameter string       B_INPUT   = "DIRECT",
  parameter int unsigned IN_DEPTH  = 1,
  parameter int unsigned B1REG     = 1,
  parameter int unsigned OPMODEREG = 1,
  parameter int unsigned SATURATE  = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] bcin_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             opmode4_i,
  input  logic             opmode6_i,
  input  logic             ce_i,
  input  logic             rstb_i,
  input  logic             rstd_i,
  input  logic             in_vld_i,
  output logic [WIDTH-1:0] out_b1_o,
  output logic [WIDTH-1:0] bcout_o,
  output logic             ovf_o,
  output logic             out_vld_o
);

  // With no input stages there is nothing to align the opcode with, so it stays combinational.
  localparam int unsigned OpDepth = (OPMODEREG != 0 && IN_DEPTH != 0) ? 1 : 0;
  localparam int unsigned Lat     = IN_DEPTH + B1REG;

  logic [WIDTH-1:0] b_src, b_s, d_s;
  logic [WIDTH-1:0] preadd_res, b1_in;
  logic             preadd_ovf, ovf_in;
  opmode_t          op_in, op_s;

  if (B_INPUT == BInputCascade) begin : g_cascade
    logic unused_b;
    assign unused_b = ^b_i;
    assign b_src    = bcin_i;
  end else begin : g_direct
    logic unused_bcin;
    assign unused_bcin = ^bcin_i;
    assign b_src       = b_i;
  end

  preadd_port_bd_pipe_reg #(.W(WIDTH), .DEPTH(IN_DEPTH)) u_b_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ce_i  (ce_i),
    .clr_i (rstb_i),
    .d_i   (b_src),
    .q_o   (b_s)
  );

  preadd_port_bd_pipe_reg #(.W(WIDTH), .DEPTH(IN_DEPTH)) u_d_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ce_i  (ce_i),
    .clr_i (rstd_i),
    .d_i   (d_i),
    .q_o   (d_s)
  );

  // Opcode register sits beside the last input stage; reset value 0 = B bypass with add.
  assign op_in = '{sub: opmode6_i, preadd: opmode4_i};

  preadd_port_bd_pipe_reg #(.W($bits(opmode_t)), .DEPTH(OpDepth)) u_op_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ce_i  (ce_i),
    .clr_i (1'b0),
    .d_i   (op_in),
    .q_o   (op_s)
  );

  if (SATURATE != 0) begin : g_sat
    localparam logic [47:0]      SatMaxFull = sat_limit(WIDTH, 1'b0);
    localparam logic [47:0]      SatMinFull = sat_limit(WIDTH, 1'b1);
    localparam logic [WIDTH-1:0] SatMax     = SatMaxFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SatMin     = SatMinFull[WIDTH-1:0];
    logic [WIDTH:0] sum;

    always_comb begin
      sum = op_s.sub ? ({d_s[WIDTH-1], d_s} - {b_s[WIDTH-1], b_s})
                     : ({d_s[WIDTH-1], d_s} + {b_s[WIDTH-1], b_s});
      preadd_res = sum[WIDTH-1:0];
      preadd_ovf = 1'b0;
      // Signed overflow shows as disagreement between the extra sign bit and the result MSB.
      if (sum[WIDTH] != sum[WIDTH-1]) begin
        preadd_ovf = 1'b1;
        preadd_res = sum[WIDTH] ? SatMin : SatMax;
      end
    end
  end else begin : g_wrap
    logic [WIDTH:0] sum;

    always_comb begin
      sum = op_s.sub ? ({1'b0, d_s} - {1'b0, b_s}) : ({1'b0, d_s} + {1'b0, b_s});
      // Bit WIDTH is the carry for add and the borrow for subtract.
      preadd_res = sum[WIDTH-1:0];
      preadd_ovf = sum[WIDTH];
    end
  end

  assign b1_in  = op_s.preadd ? preadd_res : b_s;
  assign ovf_in = op_s.preadd & preadd_ovf;

  preadd_port_bd_pipe_reg #(.W(WIDTH + 1), .DEPTH(B1REG)) u_b1_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ce_i  (ce_i),
    .clr_i (rstb_i),
    .d_i   ({ovf_in, b1_in}),
    .q_o   ({ovf_o, out_b1_o})
  );

  preadd_port_bd_pipe_reg #(.W(1), .DEPTH(Lat)) u_vld_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ce_i  (ce_i),
    .clr_i (1'b0),
    .d_i   (in_vld_i),
    .q_o   (out_vld_o)
  );

  assign bcout_o = out_b1_o;

endmodule

// File: tb/tb_preadd_port_bd.sv
// Scoreboard bench: four configurations of preadd_port_bd share one stimulus stream. Each enabled
// cycle the reference model turns finished samples into expected results queued per instance;
// a negedge monitor pops and compares whenever an instance presents a fresh valid output.
module tb_preadd_port_bd;
  localparam int W    = 18;
  localparam int NDUT = 4;
  localparam int HIST = 4096;

  // Instance configurations (must match the instantiations below).
  //  0: DIRECT  IN_DEPTH=1 B1REG=1 OPMODEREG=1 wrap      -> latency 2
  //  1: CASCADE IN_DEPTH=2 B1REG=0 OPMODEREG=1 saturate  -> latency 2
  //  2: DIRECT  IN_DEPTH=0 B1REG=0 OPMODEREG=1 wrap      -> latency 0
  //  3: DIRECT  IN_DEPTH=2 B1REG=1 OPMODEREG=0 saturate  -> latency 3
  function automatic int cfg_depth(int i);
    case (i) 0: return 1; 1: return 2; 2: return 0; default: return 2; endcase
  endfunction
  function automatic int cfg_b1reg(int i);
    case (i) 0: return 1; 1: return 0; 2: return 0; default: return 1; endcase
  endfunction
  // Number of input stages the opcode skips (1 when it is registered in the last input stage).
  function automatic int cfg_opreg(int i);
    case (i) 0: return 1; 1: return 1; default: return 0; endcase
  endfunction
  function automatic bit cfg_sat(int i);
    return (i == 1) || (i == 3);
  endfunction
  function automatic bit cfg_casc(int i);
    return i == 1;
  endfunction
  function automatic int cfg_lat(int i);
    return cfg_depth(i) + cfg_b1reg(i);
  endfunction

  typedef struct {
    logic [W-1:0]    b, bcin, d;
    logic            vld;
    logic [NDUT-1:0] dkill;
    int              stamp;
  } smp_t;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           due;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ce = 1'b0, rstb = 1'b0, rstd = 1'b0, in_vld = 1'b0, op4 = 1'b0, op6 = 1'b0;
  logic [W-1:0] b = '0, bcin = '0, d = '0;
  logic [W-1:0] out_b1 [NDUT];
  logic [W-1:0] bcout  [NDUT];
  logic         ovf    [NDUT];
  logic         out_vld[NDUT];

  smp_t hist [HIST];
  exp_t exp_q [NDUT][$];
  exp_t held  [NDUT];
  int   j = 0;      // enabled cycles since the last reset, as seen by the model
  int   ecnt = 0;   // enabled clock edges so far
  logic last_ce = 1'b0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    last_ce <= ce;
    if (ce) ecnt <= ecnt + 1;
  end

  preadd_port_bd #(.WIDTH(W), .B_INPUT("DIRECT"), .IN_DEPTH(1), .B1REG(1), .OPMODEREG(1),
                   .SATURATE(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .b_i(b), .bcin_i(bcin), .d_i(d), .opmode4_i(op4),
    .opmode6_i(op6), .ce_i(ce), .rstb_i(rstb), .rstd_i(rstd), .in_vld_i(in_vld),
    .out_b1_o(out_b1[0]), .bcout_o(bcout[0]), .ovf_o(ovf[0]), .out_vld_o(out_vld[0]));

  preadd_port_bd #(.WIDTH(W), .B_INPUT("CASCADE"), .IN_DEPTH(2), .B1REG(0), .OPMODEREG(1),
                   .SATURATE(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .b_i(b), .bcin_i(bcin), .d_i(d), .opmode4_i(op4),
    .opmode6_i(op6), .ce_i(ce), .rstb_i(rstb), .rstd_i(rstd), .in_vld_i(in_vld),
    .out_b1_o(out_b1[1]), .bcout_o(bcout[1]), .ovf_o(ovf[1]), .out_vld_o(out_vld[1]));

  preadd_port_bd #(.WIDTH(W), .B_INPUT("DIRECT"), .IN_DEPTH(0), .B1REG(0), .OPMODEREG(1),
                   .SATURATE(0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .b_i(b), .bcin_i(bcin), .d_i(d), .opmode4_i(op4),
    .opmode6_i(op6), .ce_i(ce), .rstb_i(rstb), .rstd_i(rstd), .in_vld_i(in_vld),
    .out_b1_o(out_b1[2]), .bcout_o(bcout[2]), .ovf_o(ovf[2]), .out_vld_o(out_vld[2]));

  preadd_port_bd #(.WIDTH(W), .B_INPUT("DIRECT"), .IN_DEPTH(2), .B1REG(1), .OPMODEREG(0),
                   .SATURATE(1)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .b_i(b), .bcin_i(bcin), .d_i(d), .opmode4_i(op4),
    .opmode6_i(op6), .ce_i(ce), .rstb_i(rstb), .rstd_i(rstd), .in_vld_i(in_vld),
    .out_b1_o(out_b1[3]), .bcout_o(bcout[3]), .ovf_o(ovf[3]), .out_vld_o(out_vld[3]));

  task automatic chk(input bit ok, input string name, input int dut, input longint act,
                     input longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, dut, act, expv, $time);
    end
  endtask

  // Pre-adder arithmetic on plain integers.
  function automatic exp_t model(logic [W-1:0] bv, logic [W-1:0] dv, logic o4, logic o6, bit sat);
    exp_t e;
    int   s;
    e.due = 0;
    if (!o4) begin
      e.res = bv;
      e.ovf = 1'b0;
    end else if (!sat) begin
      s     = o6 ? int'(dv) - int'(bv) : int'(dv) + int'(bv);
      e.ovf = (s < 0) || (s >= 2 ** W);
      e.res = s[W-1:0];
    end else begin
      s     = o6 ? int'($signed(dv)) - int'($signed(bv)) : int'($signed(dv)) + int'($signed(bv));
      e.ovf = 1'b0;
      if (s > 2 ** (W - 1) - 1) begin
        s     = 2 ** (W - 1) - 1;
        e.ovf = 1'b1;
      end else if (s < -(2 ** (W - 1))) begin
        s     = -(2 ** (W - 1));
        e.ovf = 1'b1;
      end
      e.res = s[W-1:0];
    end
    return e;
  endfunction

  // One enabled cycle: record the sample, apply RSTD to every sample still inside (or entering)
  // an instance's D input stages, then emit results whose opcode is now known.
  task automatic model_step();
    int           kk;
    exp_t         e;
    logic [W-1:0] bsel, dsel;
    hist[j] = '{b: b, bcin: bcin, d: d, vld: in_vld, dkill: '0, stamp: ecnt};
    for (int i = 0; i < NDUT; i++) begin
      if (rstd) begin
        for (int k = j - cfg_depth(i) + 1; k <= j; k++) begin
          if (k >= 0) hist[k].dkill[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      kk = j - (cfg_depth(i) - cfg_opreg(i));
      if (kk >= 0 && hist[kk].vld) begin
        bsel  = cfg_casc(i) ? hist[kk].bcin : hist[kk].b;
        dsel  = hist[kk].dkill[i] ? '0 : hist[kk].d;
        e     = model(bsel, dsel, op4, op6, cfg_sat(i));
        e.due = hist[kk].stamp + cfg_lat(i);
        exp_q[i].push_back(e);
      end
    end
    j++;
  endtask

  task automatic drive(input logic cev, input logic vldv, input logic rstdv, input logic o4,
                       input logic o6, input logic [W-1:0] bv, input logic [W-1:0] bcv,
                       input logic [W-1:0] dv);
    @(posedge clk);
    #1;
    ce = cev; in_vld = vldv & cev; rstd = rstdv & cev;
    op4 = o4; op6 = o6; b = bv; bcin = bcv; d = dv;
    if (cev) model_step();
  endtask

  // Keep operands and opcode, enabled or stalled, with no new sample.
  task automatic idle(input int n, input logic cev);
    for (int k = 0; k < n; k++) drive(cev, 1'b0, 1'b0, op4, op6, b, bcin, d);
  endtask

  task automatic check_cleared(input string name);
    for (int i = 0; i < NDUT; i++) begin
      if (cfg_lat(i) != 0) begin
        chk(out_b1[i] === '0, {name, "_b1"}, i, longint'(out_b1[i]), 0);
        chk(ovf[i] === 1'b0, {name, "_ovf"}, i, longint'(ovf[i]), 0);
        chk(out_vld[i] === 1'b0, {name, "_vld"}, i, longint'(out_vld[i]), 0);
      end
    end
  endtask

  // Monitor: a valid output is fresh after an enabled edge (or, for the combinational instance,
  // during an enabled cycle); otherwise it must still show the last result.
  always @(negedge clk) begin
    exp_t e;
    bit   fresh;
    if (rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        chk(bcout[i] === out_b1[i], "bcout_eq_b1", i, longint'(bcout[i]), longint'(out_b1[i]));
        if (out_vld[i] === 1'b1) begin
          fresh = (cfg_lat(i) == 0) ? bit'(ce) : bit'(last_ce);
          if (fresh) begin
            if (exp_q[i].size() == 0) begin
              chk(1'b0, "unexpected_valid", i, longint'(out_b1[i]), -1);
            end else begin
              e = exp_q[i].pop_front();
              chk(out_b1[i] === e.res, "result", i, longint'(out_b1[i]), longint'(e.res));
              chk(ovf[i] === e.ovf, "ovf", i, longint'(ovf[i]), longint'(e.ovf));
              chk(ecnt == e.due, "latency_edge", i, longint'(ecnt), longint'(e.due));
              held[i] = e;
            end
          end else begin
            chk(out_b1[i] === held[i].res, "stall_hold", i, longint'(out_b1[i]),
                longint'(held[i].res));
            chk(ovf[i] === held[i].ovf, "stall_hold_ovf", i, longint'(ovf[i]),
                longint'(held[i].ovf));
          end
        end
      end
    end
  end

  initial begin
    // Power-on reset.
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // Directed values, each sample isolated by idle cycles with the opcode held.
    drive(1, 1, 0, 1, 0, W'(30), W'(0), W'(100));       idle(4, 1);   // 130
    drive(1, 1, 0, 1, 1, W'(100), W'(0), W'(30));       idle(4, 1);   // wrap: 0x3FFBA, ovf
    drive(1, 1, 0, 1, 0, W'(1000), W'(1000), W'(131000)); idle(4, 1); // sat high
    drive(1, 1, 0, 1, 1, W'(1000), W'(1000), 18'h20048); idle(4, 1);  // D=-131000: sat low
    drive(1, 1, 0, 0, 0, 18'h2AAAA, 18'h2AAAA, W'(5));  idle(4, 1);   // bypass
    drive(1, 1, 0, 0, 0, W'(9), W'(7), W'(5));          idle(4, 1);   // cascade picks BCIN
    drive(1, 1, 1, 1, 0, W'(10), W'(10), W'(50));       idle(4, 1);   // RSTD clears D path

    // Bypass stream 1,2,3 with a three-cycle stall in the middle.
    drive(1, 1, 0, 0, 0, W'(1), W'(1), W'(0));
    drive(1, 1, 0, 0, 0, W'(2), W'(2), W'(0));
    idle(3, 0);
    drive(1, 1, 0, 0, 0, W'(3), W'(3), W'(0));
    idle(5, 1);

    // Asynchronous reset between edges with samples in flight.
    for (int k = 0; k < 4; k++) drive(1, 1, 0, 1, 0, W'(k + 11), W'(k + 21), W'(k + 31));
    @(posedge clk);
    #1 ce = 1'b0; in_vld = 1'b0; rstd = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_cleared("async_reset");
    for (int i = 0; i < NDUT; i++) exp_q[i].delete();
    j = 0;
    #2 rst_n = 1'b1;
    drive(1, 1, 0, 1, 0, W'(5), W'(6), W'(7));
    idle(5, 1);

    // Randomised traffic: stalls, RSTD hits, both opcodes, full-range operands.
    for (int k = 0; k < 1500; k++) begin
      drive(($urandom % 5) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
            1'($urandom), 1'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end
    idle(8, 1);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk(exp_q[i].size() == 0, "drain_pending", i, longint'(exp_q[i].size()), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
